np_mac_array: RTL and testbench
===============================

NP_MAC_ARRAY -- requirements
Module: np_mac_array

Interface
REQ-001 SHALL have parameter IN_W, default 8, signed operand width.
REQ-002 SHALL have parameter ACC_W, default 24, signed accumulator width; ACC_W >= 2*IN_W+clog2(DEPTH).
REQ-003 SHALL have parameter OUT_W, default 8, signed result width per lane.
REQ-004 SHALL have parameter LANES, default 4, number of parallel neurons sharing one feature stream.
REQ-005 SHALL have parameter DEPTH, default 16, dot-product length in beats (>=1).
REQ-006 SHALL have parameter NUM_BUF, default 2, number of feature buffers (>=2).
REQ-007 SHALL have parameter SHIFT, default 0, arithmetic right shift applied before saturation.
REQ-008 SHALL have parameter RELU, default 0, clamp negative results to zero when 1.
REQ-009 clock  in  1  rising-edge clock.
REQ-010 reset  in  1  asynchronous, active-low reset.
REQ-011 in_valid  in  1  feature/weight beat present.
REQ-012 in_ready  out  1  beat accepted when in_valid&&in_ready.
REQ-013 feature  in  IN_W  signed feature pixel, shared by all lanes.
REQ-014 weight  in  LANES*IN_W  signed weights, lane i at [i*IN_W +: IN_W].
REQ-015 bias  in  LANES*ACC_W  signed per-lane bias, sampled on beat 0.
REQ-016 buf_addr  out  clog2(DEPTH)  index of the beat currently requested.
REQ-017 reading_frame  out  NUM_BUF  one-hot buffer select.
REQ-018 out_valid  out  1  result available.
REQ-019 out_ready  in  1  consumer accepts result.
REQ-020 out_data  out  LANES*OUT_W  per-lane results.
REQ-021 sat  out  LANES  per-lane saturation flag, qualified by out_valid.

Function
REQ-022 SHALL implement two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-023 On an accepted beat with count==0, acc[i] SHALL load bias[i] + feature*weight[i].
REQ-024 On an accepted beat with count>0, acc[i] SHALL load acc[i] + feature*weight[i]; products are full 2*IN_W signed, sign-extended to ACC_W, and the sum wraps modulo 2^ACC_W.
REQ-025 count SHALL increment only on accepted beats; buf_addr SHALL equal count; no beat accepted means no change.
REQ-026 The beat accepted at count==DEPTH-1 SHALL be included in the sum; the FSM SHALL enter HOLD on the next edge with out_data registered from the complete sum (latency 1 cycle after the last beat).
REQ-027 On that same edge count SHALL return to 0 and reading_frame SHALL rotate left by one (bit NUM_BUF-1 wraps to bit 0).
REQ-028 Result per lane: acc >>> SHIFT, then RELU clamp if enabled, then saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; sat[i]=1 iff clamping to an OUT_W bound occurred (RELU zeroing alone does not set sat).
REQ-029 In HOLD, out_data/sat SHALL stay stable until out_valid&&out_ready; on that edge the FSM SHALL return to ACCUM (no same-cycle bypass: in_ready rises the cycle after the handshake).
REQ-030 DEPTH==1 SHALL produce a result for every beat, i.e. bias+product, with one bubble per result.
REQ-031 in_valid is ignored while in HOLD; inputs SHALL not affect acc or count.

Reset
REQ-032 Reset assertion SHALL at any time, including mid-accumulation or in HOLD, force state=ACCUM, count=0, acc=0, out_data=0, sat=0, out_valid=0, reading_frame=1 (buffer 0), and discard partial sums.
REQ-033 in_ready SHALL read 1 from the first cycle after reset release.

Verification (IN_W=8, ACC_W=24, OUT_W=8, LANES=2, DEPTH=4, NUM_BUF=3, SHIFT=0, RELU=0)
REQ-034 Four beats feature=2, weights {3,-1}, bias {1,0}, out_ready=1 -> out_valid one cycle after beat 3, out_data {25,-8}, sat=0, reading_frame 001->010.
REQ-035 Feature=127, weights {127,-128}, bias 0, 4 beats -> out_data {127,-128}, sat=2'b11.
REQ-036 in_valid toggled every other cycle -> same result as back-to-back; buf_addr only advances on accepted beats.
REQ-037 out_ready held 0 for 5 cycles in HOLD -> out_data stable, in_ready=0, inputs ignored; release -> in_ready=1 next cycle; three results rotate reading_frame 001->010->100->001.
REQ-038 Reset pulsed after beat 2 -> all outputs at reset values; next 4 beats produce a result with no contribution from the pre-reset beats.
REQ-039 Rerun with SHIFT=2, RELU=1, sum -40 -> out_data 0, sat=0; sum 1000 -> 127, sat=1.

Source files
------------

// File: rtl/np_mac_array.sv
// np_mac_array: a group of LANES neurons that share one feature stream.
// Each lane forms a dot product of DEPTH beats plus a bias. The result is
// shifted, optionally clamped by ReLU, saturated to OUT_W bits and held
// until the consumer takes it.
module np_mac_array #(
    parameter int IN_W    = 8,
    parameter int ACC_W   = 24,
    parameter int OUT_W   = 8,
    parameter int LANES   = 4,
    parameter int DEPTH   = 16,
    parameter int NUM_BUF = 2,
    parameter int SHIFT   = 0,
    parameter int RELU    = 0,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_W-1:0]        feature,
    input  logic [LANES*IN_W-1:0]  weight,
    input  logic [LANES*ACC_W-1:0] bias,
    output logic [ADDR_W-1:0]      buf_addr,
    output logic [NUM_BUF-1:0]     reading_frame,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_data,
    output logic [LANES-1:0]       sat
);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(DEPTH - 1);
    localparam logic signed [ACC_W-1:0] OUT_MAX =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN =
        {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    // Shift, optional ReLU, then saturate. Bit OUT_W of the result is the
    // saturation flag. ReLU zeroing by itself never sets that flag.
    function automatic logic [OUT_W:0] post_process(input logic signed [ACC_W-1:0] acc_v);
        logic signed [ACC_W-1:0] val_v;
        logic [OUT_W:0]          res_v;
        val_v = acc_v >>> SHIFT;
        if ((RELU != 32'sd0) && val_v[ACC_W-1]) begin
            val_v = {ACC_W{1'b0}};
        end
        if (val_v > OUT_MAX) begin
            res_v = {1'b1, OUT_MAX[OUT_W-1:0]};
        end else if (val_v < OUT_MIN) begin
            res_v = {1'b1, OUT_MIN[OUT_W-1:0]};
        end else begin
            res_v = {1'b0, val_v[OUT_W-1:0]};
        end
        return res_v;
    endfunction

    state_t                  state_r;
    state_t                  state_s;
    logic                    in_ready_r;
    logic                    out_valid_r;
    logic [ADDR_W-1:0]       count_r;
    logic [NUM_BUF-1:0]      frame_r;
    logic [LANES*OUT_W-1:0]  out_data_r;
    logic [LANES-1:0]        sat_r;
    logic signed [ACC_W-1:0] acc_r  [LANES];
    logic signed [ACC_W-1:0] sum_s  [LANES];
    logic signed [2*IN_W-1:0] prod_s [LANES];
    logic [OUT_W:0]          res_s  [LANES];
    logic                    accept_s;
    logic                    last_beat_s;

    assign accept_s      = in_valid && (state_r == ST_ACCUM);
    assign last_beat_s   = accept_s && (count_r == LAST_CNT);
    assign in_ready      = in_ready_r;
    assign out_valid     = out_valid_r;
    assign buf_addr      = count_r;
    assign reading_frame = frame_r;
    assign out_data      = out_data_r;
    assign sat           = sat_r;

    // Next-state logic: ACCUM until the last beat is taken, HOLD until the result is consumed.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_ACCUM: begin
                if (last_beat_s) begin
                    state_s = ST_HOLD;
                end else begin
                    state_s = ST_ACCUM;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_s = ST_ACCUM;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: state_s = ST_ACCUM;
        endcase
    end

    // State register. The handshake flags are registered from the next state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_ACCUM;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == ST_ACCUM);
            out_valid_r <= (state_s == ST_HOLD);
        end
    end

    // Per-lane sum for the current beat. Beat 0 starts from bias, not from the old acc.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod_s[i] = (2*IN_W)'($signed(feature)) *
                        (2*IN_W)'($signed(weight[i*IN_W +: IN_W]));
            if (count_r == {ADDR_W{1'b0}}) begin
                sum_s[i] = $signed(bias[i*ACC_W +: ACC_W]) + ACC_W'(prod_s[i]);
            end else begin
                sum_s[i] = acc_r[i] + ACC_W'(prod_s[i]);
            end
            res_s[i] = post_process(sum_s[i]);
        end
    end

    // Datapath: accumulate on accepted beats. On the last beat, capture the result and rotate the buffer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r    <= {ADDR_W{1'b0}};
            frame_r    <= NUM_BUF'(1);
            out_data_r <= {(LANES*OUT_W){1'b0}};
            sat_r      <= {LANES{1'b0}};
            for (int i = 0; i < LANES; i++) begin
                acc_r[i] <= {ACC_W{1'b0}};
            end
        end else if (accept_s) begin
            for (int i = 0; i < LANES; i++) begin
                acc_r[i] <= sum_s[i];
            end
            if (last_beat_s) begin
                count_r <= {ADDR_W{1'b0}};
                frame_r <= {frame_r[NUM_BUF-2:0], frame_r[NUM_BUF-1]};
                for (int i = 0; i < LANES; i++) begin
                    out_data_r[i*OUT_W +: OUT_W] <= res_s[i][OUT_W-1:0];
                    sat_r[i]                     <= res_s[i][OUT_W];
                end
            end else begin
                count_r <= count_r + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_np_mac_array.sv
// Testbench for np_mac_array. Two instances share the same stimulus: one
// plain, one with SHIFT=2 and RELU=1. A reference model computes the
// expected dot products from the arithmetic rules.
module tb_np_mac_array;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [7:0]  feature = 8'd0;
    logic [15:0] weight = 16'd0;
    logic [47:0] bias = 48'd0;

    logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [1:0]  buf_addr_a, buf_addr_b, sat_a, sat_b;
    logic [2:0]  frame_a, frame_b;
    logic [15:0] out_data_a, out_data_b;

    int vectors = 0;
    int miscompares = 0;
    int f_a [4];
    int w0_a [4];
    int w1_a [4];
    int b0 = 0;
    int b1 = 0;
    logic [2:0] exp_frame = 3'b001;

    always #5 clock = ~clock;

    np_mac_array #(.IN_W(8), .ACC_W(24), .OUT_W(8), .LANES(2), .DEPTH(4),
                   .NUM_BUF(3), .SHIFT(0), .RELU(0)) dut_a (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
        .feature(feature), .weight(weight), .bias(bias), .buf_addr(buf_addr_a),
        .reading_frame(frame_a), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .sat(sat_a));

    np_mac_array #(.IN_W(8), .ACC_W(24), .OUT_W(8), .LANES(2), .DEPTH(4),
                   .NUM_BUF(3), .SHIFT(2), .RELU(1)) dut_b (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
        .feature(feature), .weight(weight), .bias(bias), .buf_addr(buf_addr_b),
        .reading_frame(frame_b), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .sat(sat_b));

    // Reference for one lane: bias plus the dot product, wrapped to 24 bits,
    // then shift, ReLU and saturation. Returns {sat, data[7:0]}.
    function automatic logic [8:0] model_lane(input int lane, input int shift, input int relu);
        longint s;
        bit     st;
        s = (lane == 0) ? longint'(b0) : longint'(b1);
        for (int k = 0; k < 4; k++) begin
            s = s + longint'(f_a[k]) * longint'((lane == 0) ? w0_a[k] : w1_a[k]);
        end
        s = s & 64'h0000_0000_00FF_FFFF;
        if (s >= 64'sd8388608) s = s - 64'sd16777216;
        s = s >>> shift;
        if (relu != 0 && s < 0) s = 0;
        st = 1'b0;
        if (s > 127) begin s = 127; st = 1'b1; end
        else if (s < -128) begin s = -128; st = 1'b1; end
        return {st, s[7:0]};
    endfunction

    // Expected {sat[1:0], out_data[15:0]} for the current frame.
    function automatic logic [17:0] model_pack(input int shift, input int relu);
        logic [8:0] l0, l1;
        l0 = model_lane(0, shift, relu);
        l1 = model_lane(1, shift, relu);
        return {l1[8], l0[8], l1[7:0], l0[7:0]};
    endfunction

    task automatic rand_frame();
        logic signed [23:0] t24;
        for (int k = 0; k < 4; k++) begin
            f_a[k]  = int'($urandom_range(0, 255)) - 128;
            w0_a[k] = int'($urandom_range(0, 255)) - 128;
            w1_a[k] = int'($urandom_range(0, 255)) - 128;
        end
        if ($urandom_range(0, 3) == 0) begin
            t24 = 24'($urandom()); b0 = int'(t24);
            t24 = 24'($urandom()); b1 = int'(t24);
        end else begin
            b0 = int'($urandom_range(0, 4000)) - 2000;
            b1 = int'($urandom_range(0, 4000)) - 2000;
        end
    endtask

    // Drive n beats back to back. Bias is only valid on beat 0; later beats get junk.
    task automatic play_frame(input int n);
        for (int k = 0; k < n; k++) begin
            feature  = f_a[k][7:0];
            weight   = {w1_a[k][7:0], w0_a[k][7:0]};
            bias     = (k == 0) ? {b1[23:0], b0[23:0]} : {16'($urandom()), $urandom()};
            in_valid = 1'b1;
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20 && !in_ready_a; i++) begin
            @(posedge clock); #1;
        end
        vectors++;
        if (in_ready_a !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_ready: in_ready=%b required 1 within 20 cycles", in_ready_a);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        #1;
        vectors++;
        if ({in_ready_a, out_valid_a, frame_a, buf_addr_a, out_data_a, sat_a} !==
            {1'b1, 1'b0, 3'b001, 2'b00, 16'h0000, 2'b00}) begin
            miscompares++;
            $display("FAIL reset_a: got rdy=%b vld=%b frame=%b addr=%0d data=%h sat=%b required 1 0 001 0 0000 00",
                     in_ready_a, out_valid_a, frame_a, buf_addr_a, out_data_a, sat_a);
        end
        vectors++;
        if ({in_ready_b, out_valid_b, frame_b, out_data_b} !== {1'b1, 1'b0, 3'b001, 16'h0000}) begin
            miscompares++;
            $display("FAIL reset_b: got rdy=%b vld=%b frame=%b data=%h", in_ready_b, out_valid_b, frame_b, out_data_b);
        end
    endtask

    task automatic test_directed();
        out_ready = 1'b1;
        wait_ready();
        for (int k = 0; k < 4; k++) begin f_a[k] = 2; w0_a[k] = 3; w1_a[k] = -1; end
        b0 = 1; b1 = 0;
        play_frame(4);
        exp_frame = {exp_frame[1:0], exp_frame[2]};
        vectors++;
        if ({out_valid_a, in_ready_a, sat_a, out_data_a, frame_a} !== {1'b1, 1'b0, 2'b00, 16'hF819, 3'b010}) begin
            miscompares++;
            $display("FAIL directed: got vld=%b rdy=%b sat=%b data=%h frame=%b required 1 0 00 f819 010",
                     out_valid_a, in_ready_a, sat_a, out_data_a, frame_a);
        end
        vectors++;
        if ({sat_b, out_data_b} !== model_pack(2, 1)) begin
            miscompares++;
            $display("FAIL directed_b: got %h required %h", {sat_b, out_data_b}, model_pack(2, 1));
        end
        @(posedge clock); #1;
        vectors++;
        if ({in_ready_a, out_valid_a} !== 2'b10) begin
            miscompares++;
            $display("FAIL directed_release: got rdy=%b vld=%b required 1 0", in_ready_a, out_valid_a);
        end
    endtask

    task automatic test_saturate();
        wait_ready();
        for (int k = 0; k < 4; k++) begin f_a[k] = 127; w0_a[k] = 127; w1_a[k] = -128; end
        b0 = 0; b1 = 0;
        play_frame(4);
        exp_frame = {exp_frame[1:0], exp_frame[2]};
        vectors++;
        if ({out_valid_a, sat_a, out_data_a, frame_a} !== {1'b1, 2'b11, 16'h807F, exp_frame}) begin
            miscompares++;
            $display("FAIL saturate: got vld=%b sat=%b data=%h frame=%b required 1 11 807f %b",
                     out_valid_a, sat_a, out_data_a, frame_a, exp_frame);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_gapped();
        int k;
        wait_ready();
        rand_frame();
        k = 0;
        for (int cyc = 0; cyc < 7; cyc++) begin
            vectors++;
            if (buf_addr_a !== 2'(k)) begin
                miscompares++;
                $display("FAIL gapped_addr: cycle %0d got %0d required %0d", cyc, buf_addr_a, k);
            end
            if (cyc % 2 == 0) begin
                feature  = f_a[k][7:0];
                weight   = {w1_a[k][7:0], w0_a[k][7:0]};
                bias     = (k == 0) ? {b1[23:0], b0[23:0]} : {16'($urandom()), $urandom()};
                in_valid = 1'b1;
            end else begin
                feature  = 8'($urandom());
                weight   = 16'($urandom());
                in_valid = 1'b0;
            end
            @(posedge clock); #1;
            if (cyc % 2 == 0) k++;
        end
        in_valid = 1'b0;
        exp_frame = {exp_frame[1:0], exp_frame[2]};
        vectors++;
        if ({out_valid_a, sat_a, out_data_a, frame_a} !== {1'b1, model_pack(0, 0), exp_frame}) begin
            miscompares++;
            $display("FAIL gapped_result: got vld=%b %h frame=%b required 1 %h %b",
                     out_valid_a, {sat_a, out_data_a}, frame_a, model_pack(0, 0), exp_frame);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_hold();
        for (int r = 0; r < 3; r++) begin
            out_ready = 1'b0;
            wait_ready();
            rand_frame();
            play_frame(4);
            exp_frame = {exp_frame[1:0], exp_frame[2]};
            vectors++;
            if (frame_a !== exp_frame) begin
                miscompares++;
                $display("FAIL hold_frame: result %0d got %b required %b", r, frame_a, exp_frame);
            end
            for (int c = 0; c < 5; c++) begin
                in_valid = 1'b1;
                feature  = 8'($urandom());
                weight   = 16'($urandom());
                @(posedge clock); #1;
                vectors++;
                if ({out_valid_a, in_ready_a, buf_addr_a, sat_a, out_data_a} !==
                    {1'b1, 1'b0, 2'b00, model_pack(0, 0)}) begin
                    miscompares++;
                    $display("FAIL hold_stable: cycle %0d got vld=%b rdy=%b addr=%0d %h required 1 0 0 %h",
                             c, out_valid_a, in_ready_a, buf_addr_a, {sat_a, out_data_a}, model_pack(0, 0));
                end
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(posedge clock); #1;
            vectors++;
            if ({in_ready_a, out_valid_a} !== 2'b10) begin
                miscompares++;
                $display("FAIL hold_release: got rdy=%b vld=%b required 1 0", in_ready_a, out_valid_a);
            end
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        wait_ready();
        rand_frame();
        play_frame(2);
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({in_ready_a, out_valid_a, frame_a, buf_addr_a, out_data_a, sat_a} !==
            {1'b1, 1'b0, 3'b001, 2'b00, 16'h0000, 2'b00}) begin
            miscompares++;
            $display("FAIL reset_mid: got rdy=%b vld=%b frame=%b addr=%0d data=%h sat=%b",
                     in_ready_a, out_valid_a, frame_a, buf_addr_a, out_data_a, sat_a);
        end
        @(posedge clock); #1 reset = 1'b1;
        exp_frame = 3'b001;
        rand_frame();
        play_frame(4);
        exp_frame = {exp_frame[1:0], exp_frame[2]};
        vectors++;
        if ({out_valid_a, sat_a, out_data_a, frame_a} !== {1'b1, model_pack(0, 0), exp_frame}) begin
            miscompares++;
            $display("FAIL reset_mid_result: got vld=%b %h frame=%b required 1 %h %b",
                     out_valid_a, {sat_a, out_data_a}, frame_a, model_pack(0, 0), exp_frame);
        end
        @(posedge clock); #1;
        // Reset while a result is being held.
        out_ready = 1'b0;
        wait_ready();
        rand_frame();
        play_frame(4);
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({in_ready_a, out_valid_a, frame_a, out_data_a, sat_a} !== {1'b1, 1'b0, 3'b001, 16'h0000, 2'b00}) begin
            miscompares++;
            $display("FAIL reset_hold: got rdy=%b vld=%b frame=%b data=%h sat=%b",
                     in_ready_a, out_valid_a, frame_a, out_data_a, sat_a);
        end
        @(posedge clock); #1 reset = 1'b1;
        exp_frame = 3'b001;
        out_ready = 1'b1;
    endtask

    task automatic test_shift_relu();
        wait_ready();
        for (int k = 0; k < 4; k++) begin
            f_a[k] = 0; w0_a[k] = int'($urandom_range(0, 255)) - 128; w1_a[k] = 5;
        end
        b0 = -40; b1 = 1000;
        play_frame(4);
        exp_frame = {exp_frame[1:0], exp_frame[2]};
        vectors++;
        if ({out_valid_b, sat_b, out_data_b} !== {1'b1, 2'b10, 16'h7F00}) begin
            miscompares++;
            $display("FAIL shift_relu: got vld=%b sat=%b data=%h required 1 10 7f00", out_valid_b, sat_b, out_data_b);
        end
        vectors++;
        if ({sat_a, out_data_a} !== {2'b10, 16'h7FD8}) begin
            miscompares++;
            $display("FAIL shift_relu_plain: got sat=%b data=%h required 10 7fd8", sat_a, out_data_a);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 12; r++) begin
            out_ready = 1'b0;
            wait_ready();
            rand_frame();
            play_frame(4);
            exp_frame = {exp_frame[1:0], exp_frame[2]};
            vectors++;
            if ({out_valid_a, sat_a, out_data_a, frame_a} !== {1'b1, model_pack(0, 0), exp_frame}) begin
                miscompares++;
                $display("FAIL random_a: frame %0d got vld=%b %h frame=%b required 1 %h %b",
                         r, out_valid_a, {sat_a, out_data_a}, frame_a, model_pack(0, 0), exp_frame);
            end
            vectors++;
            if ({out_valid_b, sat_b, out_data_b} !== {1'b1, model_pack(2, 1)}) begin
                miscompares++;
                $display("FAIL random_b: frame %0d got vld=%b %h required 1 %h",
                         r, out_valid_b, {sat_b, out_data_b}, model_pack(2, 1));
            end
            repeat ($urandom_range(0, 3)) @(posedge clock);
            #1 out_ready = 1'b1;
            @(posedge clock); #1;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_saturate();
        test_gapped();
        test_hold();
        test_reset_mid();
        test_shift_relu();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
